// File: rtl/instruction_queue.sv
// Instruction FIFO with first-word fall-through head, flush and overflow pulse.
// Optional same-cycle bypass on empty is enabled by defining INSTR_QUEUE_BYPASS_EN.
module instruction_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [WIDTH-1:0]           Instruction_In,
    input  logic                       InstrWrite,
    input  logic                       InstrRead,
    input  logic                       Flush,
    output logic [WIDTH-1:0]           Instruction_Out,
    output logic                       Valid,
    output logic                       Full,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_bypass;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = InstrRead & ~Flush & ~w_empty;

`ifdef INSTR_QUEUE_BYPASS_EN
    assign w_bypass = w_empty & InstrWrite & ~Flush;
    // A bypassed word that is read in the same cycle is consumed, never stored.
    assign w_push   = InstrWrite & ~Flush & (~w_full | w_pop) & ~(w_bypass & InstrRead);
`else
    assign w_bypass = 1'b0;
    assign w_push   = InstrWrite & ~Flush & (~w_full | w_pop);
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (Flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= InstrWrite & w_full & ~w_pop;
            if (w_push) begin
                r_mem[r_wr_ptr] <= Instruction_In;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        Instruction_Out = '0;
        if (w_bypass) begin
            Instruction_Out = Instruction_In;
        end else if (!w_empty) begin
            Instruction_Out = r_mem[r_rd_ptr];
        end
    end

    assign Valid    = w_bypass | ~w_empty;
    assign Full     = w_full;
    assign Count    = r_count;
    assign Overflow = r_overflow;

endmodule

// File: tb/tb_instruction_queue.sv
// Scoreboard bench for instruction_queue (WIDTH=16, DEPTH=4).
module tb_instruction_queue;
    logic        Clk;
    logic        Reset_n;
    logic [15:0] Instruction_In;
    logic        InstrWrite;
    logic        InstrRead;
    logic        Flush;
    logic [15:0] Instruction_Out;
    logic        Valid;
    logic        Full;
    logic [2:0]  Count;
    logic        Overflow;

    logic [15:0] sb[$];
    logic        exp_ovf;
    int          n_checks;
    int          n_pass;

    instruction_queue #(.WIDTH(16), .DEPTH(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Instruction_In(Instruction_In),
        .InstrWrite(InstrWrite), .InstrRead(InstrRead), .Flush(Flush),
        .Instruction_Out(Instruction_Out), .Valid(Valid), .Full(Full),
        .Count(Count), .Overflow(Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic drive(input logic wr, input logic rd, input logic fl, input logic [15:0] d);
        InstrWrite     = wr;
        InstrRead      = rd;
        Flush          = fl;
        Instruction_In = d;
    endtask

    // Advances one clock, updating the reference queue from the inputs in force before the edge.
    task automatic tick();
        logic pa, wa, byp;
        logic [15:0] din;
        int n;
        n   = sb.size();
        byp = 1'b0;
        pa  = InstrRead && !Flush && (n != 0);
`ifdef INSTR_QUEUE_BYPASS_EN
        byp = (n == 0) && InstrWrite && !Flush && InstrRead;
`endif
        wa      = InstrWrite && !Flush && ((n < 4) || pa) && !byp;
        exp_ovf = InstrWrite && !Flush && (n == 4) && !pa;
        din     = Instruction_In;
        @(posedge Clk);
        #1;
        if (Flush) begin
            sb.delete();
        end else begin
            if (pa) void'(sb.pop_front());
            if (wa) sb.push_back(din);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        drive(0, 0, 0, 16'h0);
        #2;
        n_checks++;
        if (Valid !== 1'b0 || Count !== 3'd0 || Instruction_Out !== 16'h0 || Full !== 1'b0 || Overflow !== 1'b0)
            $display("FAIL reset_initial: valid=%b count=%0d out=%h full=%b ovf=%b want 0/0/0000/0/0",
                     Valid, Count, Instruction_Out, Full, Overflow);
        else n_pass++;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 16'h0100 + 16'(i));
            tick();
        end
        drive(0, 0, 0, 16'h0);
        n_checks++;
        if (Count !== 3'd3) $display("FAIL reset_prefill: count=%0d want 3", Count);
        else n_pass++;
        Reset_n = 1'b0;
        #1;
        n_checks++;
        if (Valid !== 1'b0 || Count !== 3'd0 || Instruction_Out !== 16'h0)
            $display("FAIL reset_async: valid=%b count=%0d out=%h want 0/0/0000", Valid, Count, Instruction_Out);
        else n_pass++;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        sb.delete();
        drive(1, 0, 0, 16'hBEEF);
        tick();
        drive(0, 0, 0, 16'h0);
        n_checks++;
        if (Count !== 3'd1 || Instruction_Out !== 16'hBEEF)
            $display("FAIL reset_restart: count=%0d out=%h want 1/beef", Count, Instruction_Out);
        else n_pass++;
        drive(0, 1, 0, 16'h0);
        tick();
        drive(0, 0, 0, 16'h0);
    endtask

    task automatic test_order_wrap();
        logic [15:0] want[4];
        want = '{16'h3333, 16'h4444, 16'h5555, 16'h6666};
        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, 0, 16'(i) * 16'h1111);
            tick();
        end
        drive(0, 0, 0, 16'h0);
        n_checks++;
        if (Full !== 1'b1 || Count !== 3'd4) $display("FAIL wrap_full: full=%b count=%0d want 1/4", Full, Count);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 16'h0);
            tick();
        end
        drive(1, 0, 0, 16'h5555); tick();
        drive(1, 0, 0, 16'h6666); tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 16'h0);
            #1;
            n_checks++;
            if (Valid !== 1'b1 || Instruction_Out !== want[i] || sb.size() == 0 || sb[0] !== want[i])
                $display("FAIL wrap_order[%0d]: out=%h valid=%b want %h/1", i, Instruction_Out, Valid, want[i]);
            else n_pass++;
            tick();
        end
        drive(0, 0, 0, 16'h0);
        n_checks++;
        if (Valid !== 1'b0 || Count !== 3'd0 || Instruction_Out !== 16'h0)
            $display("FAIL wrap_empty: valid=%b count=%0d out=%h want 0/0/0000", Valid, Count, Instruction_Out);
        else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 16'h0A01 + 16'(i));
            tick();
        end
        drive(1, 0, 0, 16'h7777);
        tick();
        drive(0, 0, 0, 16'h0);
        n_checks++;
        if (Count !== 3'd4 || Overflow !== 1'b1 || exp_ovf !== 1'b1)
            $display("FAIL overflow_pulse: count=%0d ovf=%b want 4/1", Count, Overflow);
        else n_pass++;
        tick();
        n_checks++;
        if (Overflow !== 1'b0) $display("FAIL overflow_one_cycle: ovf=%b want 0", Overflow);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 16'h0);
            #1;
            n_checks++;
            if (Instruction_Out === 16'h7777 || Instruction_Out !== 16'h0A01 + 16'(i))
                $display("FAIL overflow_drain[%0d]: out=%h want %h", i, Instruction_Out, 16'h0A01 + 16'(i));
            else n_pass++;
            tick();
        end
        drive(0, 0, 0, 16'h0);
    endtask

    task automatic test_full_push_pop();
        logic [15:0] want[4];
        want = '{16'h0B02, 16'h0B03, 16'h0B04, 16'h8888};
        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, 0, 16'h0B00 + 16'(i));
            tick();
        end
        drive(1, 1, 0, 16'h8888);
        #1;
        n_checks++;
        if (Instruction_Out !== 16'h0B01) $display("FAIL fullpp_head: out=%h want 0b01", Instruction_Out);
        else n_pass++;
        tick();
        drive(0, 0, 0, 16'h0);
        n_checks++;
        if (Count !== 3'd4 || Overflow !== 1'b0 || Instruction_Out !== 16'h0B02)
            $display("FAIL fullpp_state: count=%0d ovf=%b out=%h want 4/0/0b02", Count, Overflow, Instruction_Out);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 16'h0);
            #1;
            n_checks++;
            if (Instruction_Out !== want[i]) $display("FAIL fullpp_order[%0d]: out=%h want %h", i, Instruction_Out, want[i]);
            else n_pass++;
            tick();
        end
        drive(0, 0, 0, 16'h0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 16'h0C00 + 16'(i));
            tick();
        end
        drive(1, 1, 1, 16'h9999);
        tick();
        drive(0, 0, 0, 16'h0);
        n_checks++;
        if (Count !== 3'd0 || Valid !== 1'b0 || Overflow !== 1'b0)
            $display("FAIL flush_clear: count=%0d valid=%b ovf=%b want 0/0/0", Count, Valid, Overflow);
        else n_pass++;
        tick();
        n_checks++;
        if (Count !== 3'd0 || Instruction_Out !== 16'h0) $display("FAIL flush_not_stored: count=%0d out=%h want 0/0000", Count, Instruction_Out);
        else n_pass++;
    endtask

    task automatic test_empty_push_pop();
        drive(1, 1, 0, 16'hAAAA);
        #1;
        n_checks++;
`ifdef INSTR_QUEUE_BYPASS_EN
        if (Valid !== 1'b1 || Instruction_Out !== 16'hAAAA)
            $display("FAIL empty_pp_same_cycle: valid=%b out=%h want 1/aaaa", Valid, Instruction_Out);
        else n_pass++;
`else
        if (Valid !== 1'b0 || Instruction_Out !== 16'h0)
            $display("FAIL empty_pp_same_cycle: valid=%b out=%h want 0/0000", Valid, Instruction_Out);
        else n_pass++;
`endif
        tick();
        drive(0, 0, 0, 16'h0);
        n_checks++;
`ifdef INSTR_QUEUE_BYPASS_EN
        if (Count !== 3'd0) $display("FAIL empty_pp_next: count=%0d want 0", Count);
        else n_pass++;
`else
        if (Count !== 3'd1 || Instruction_Out !== 16'hAAAA)
            $display("FAIL empty_pp_next: count=%0d out=%h want 1/aaaa", Count, Instruction_Out);
        else n_pass++;
        drive(0, 1, 0, 16'h0);
        tick();
        drive(0, 0, 0, 16'h0);
`endif
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50),
                  1'($urandom_range(0, 99) < 4), 16'($urandom));
            #1;
            if (InstrRead && !Flush && sb.size() != 0) begin
                n_checks++;
                if (Instruction_Out !== sb[0]) begin
                    $display("FAIL random_head[%0d]: out=%h want %h", i, Instruction_Out, sb[0]);
                    errs++;
                end else n_pass++;
            end
            tick();
            n_checks++;
            if (Count !== 3'(sb.size()) || Overflow !== exp_ovf || Full !== (sb.size() == 4)) begin
                $display("FAIL random_state[%0d]: count=%0d ovf=%b full=%b want %0d/%b/%b",
                         i, Count, Overflow, Full, sb.size(), exp_ovf, sb.size() == 4);
                errs++;
            end else n_pass++;
            if (errs > 10) break;
        end
        drive(0, 0, 0, 16'h0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_ovf  = 1'b0;
        test_reset();
        test_order_wrap();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_empty_push_pop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
